// File: rtl/ldo_seq_pkg.sv
// rtl/ldo_seq_pkg.sv - shared state encoding and sizing helpers for the LDO power sequencer
package ldo_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ON        = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_e;

    localparam int SYNC_STAGES = 2;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/pg_sync.sv
// rtl/pg_sync.sv - multi-flop synchroniser for the asynchronous LDO power-good inputs
module pg_sync
    import ldo_seq_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pg_i,
    output logic [WIDTH-1:0] pg_s_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = pg_i;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign pg_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/ldo_power_sequencer.sv
// rtl/ldo_power_sequencer.sv - ordered ramp-up/ramp-down controller for a bank of LDO enables
module ldo_power_sequencer
    import ldo_seq_pkg::*;
#(
    parameter int  N_CH  = 3,
    parameter int  CNT_W = 16,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              seq_start_i,
    input  logic              seq_stop_i,
    input  logic [N_CH-1:0]   ch_mask_i,
    input  logic [CNT_W-1:0]  dly_i,
    input  logic [N_CH-1:0]   pg_i,
    output logic [N_CH-1:0]   ldo_en_o,
    output logic              busy_o,
    output logic              on_o,
    output logic              fault_o,
    output logic [CH_W-1:0]   fault_ch_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CH_W-1:0]  IDX_ZERO = '0;
    localparam logic [CH_W-1:0]  IDX_ONE  = CH_W'(1);
    localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(N_CH - 1);

    seq_state_e       state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [N_CH-1:0]  en_q, en_d;
    logic [CH_W-1:0]  fault_ch_q, fault_ch_d;
    logic [N_CH-1:0]  pg_s;
    logic [N_CH-1:0]  pg_bad;
    logic [CH_W-1:0]  hi_idx;
    logic [CH_W-1:0]  lo_bad;

    pg_sync #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_pg_sync (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .pg_i   (pg_i),
        .pg_s_o (pg_s)
    );

    assign pg_bad = en_q & ~pg_s;

    // Ramp-down starts at the highest enable; a fault reports the lowest bad channel.
    always_comb begin
        hi_idx = IDX_ZERO;
        lo_bad = IDX_ZERO;
        for (int i = 0; i < N_CH; i++) begin
            if (en_q[i]) hi_idx = CH_W'(i);
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pg_bad[i]) lo_bad = CH_W'(i);
        end
    end

    // cnt_q == 0 marks the entry cycle of the current channel; expiry is at 1.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        mask_d     = mask_q;
        en_d       = en_q;
        fault_ch_d = fault_ch_q;

        case (state_q)
            ST_IDLE: begin
                en_d = '0;
                if (seq_start_i && !seq_stop_i) begin
                    state_d = ST_RAMP_UP;
                    idx_d   = IDX_ZERO;
                    cnt_d   = CNT_ZERO;
                    mask_d  = ch_mask_i;
                    dly_d   = (dly_i == CNT_ZERO) ? CNT_ONE : dly_i;
                end
            end

            ST_RAMP_UP: begin
                if (seq_stop_i) begin
                    state_d = ST_RAMP_DOWN;
                    idx_d   = hi_idx;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ZERO && mask_q[idx_q]) begin
                    en_d[idx_q] = 1'b1;
                    cnt_d       = dly_q;
                end else if (cnt_q == CNT_ZERO || (cnt_q == CNT_ONE && pg_s[idx_q])) begin
                    cnt_d = CNT_ZERO;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_ON;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else if (cnt_q == CNT_ONE) begin
                    state_d    = ST_FAULT;
                    fault_ch_d = idx_q;
                    en_d       = '0;
                    cnt_d      = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ON: begin
                if (pg_bad != '0) begin
                    state_d    = ST_FAULT;
                    fault_ch_d = lo_bad;
                    en_d       = '0;
                end else if (seq_stop_i) begin
                    state_d = ST_RAMP_DOWN;
                    idx_d   = hi_idx;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_RAMP_DOWN: begin
                if (cnt_q == CNT_ZERO && en_q[idx_q]) begin
                    en_d[idx_q] = 1'b0;
                    cnt_d       = dly_q;
                end else if (cnt_q == CNT_ZERO || cnt_q == CNT_ONE) begin
                    cnt_d = CNT_ZERO;
                    if (idx_q == IDX_ZERO) begin
                        state_d = ST_IDLE;
                        en_d    = '0;
                    end else begin
                        idx_d = idx_q - IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_FAULT: begin
                en_d = '0;
                if (seq_stop_i) begin
                    state_d    = ST_IDLE;
                    fault_ch_d = IDX_ZERO;
                end
            end

            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_ZERO;
            cnt_q      <= CNT_ZERO;
            dly_q      <= CNT_ZERO;
            mask_q     <= '0;
            en_q       <= '0;
            fault_ch_q <= IDX_ZERO;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            mask_q     <= mask_d;
            en_q       <= en_d;
            fault_ch_q <= fault_ch_d;
        end
    end

    assign ldo_en_o   = en_q;
    assign busy_o     = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign on_o       = (state_q == ST_ON);
    assign fault_o    = (state_q == ST_FAULT);
    assign fault_ch_o = fault_ch_q;

endmodule

// File: tb/tb_ldo_power_sequencer.sv
// tb/tb_ldo_power_sequencer.sv - randomized self-checking bench with a schedule-based reference model
module tb_ldo_power_sequencer;

    localparam int N  = 3;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          seq_start_i;
    logic          seq_stop_i;
    logic [N-1:0]  ch_mask_i;
    logic [CW-1:0] dly_i;
    logic [N-1:0]  pg_i;
    logic [N-1:0]  ldo_en_o;
    logic          busy_o;
    logic          on_o;
    logic          fault_o;
    logic [1:0]    fault_ch_o;

    int            n_checks;
    int            n_fail;
    bit            pg_follow;
    logic [N-1:0]  en_prev;

    ldo_power_sequencer #(
        .N_CH  (N),
        .CNT_W (CW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .seq_start_i (seq_start_i),
        .seq_stop_i  (seq_stop_i),
        .ch_mask_i   (ch_mask_i),
        .dly_i       (dly_i),
        .pg_i        (pg_i),
        .ldo_en_o    (ldo_en_o),
        .busy_o      (busy_o),
        .on_o        (on_o),
        .fault_o     (fault_o),
        .fault_ch_o  (fault_ch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pg follower model: an LDO reports good one cycle after it is seen enabled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pg_follow) pg_i = en_prev;
        en_prev = ldo_en_o;
    endtask

    task automatic settle_pg(input logic [N-1:0] pg);
        pg_i = pg;
        repeat (3) tick();
    endtask

    task automatic check_outputs(input string tag, input logic [N-1:0] en, input bit busy,
                                 input bit on, input bit flt);
        check_val({tag, ".en"}, 32'(ldo_en_o), 32'(en));
        check_val({tag, ".busy"}, 32'(busy_o), 32'(busy));
        check_val({tag, ".on"}, 32'(on_o), 32'(on));
        check_val({tag, ".fault"}, 32'(fault_o), 32'(flt));
    endtask

    // Ramp-down schedule: enabled channel k clears at cycle clr[k] after entry, highest first.
    task automatic run_down(input logic [N-1:0] s, input int dd);
        int clr[N];
        int h, cur, t_idle;
        logic [N-1:0] exp_en;
        h = 0;
        for (int k = 0; k < N; k++) begin
            clr[k] = -1;
            if (s[k]) h = k;
        end
        cur = 0;
        for (int k = h; k >= 0; k--) begin
            if (s[k]) begin
                clr[k] = cur + 1;
                cur += 1 + dd;
            end else begin
                cur += 1;
            end
        end
        t_idle = cur;
        for (int c = 0; c <= t_idle; c++) begin
            exp_en = '0;
            for (int k = 0; k < N; k++) begin
                if (s[k] && clr[k] > c) exp_en[k] = 1'b1;
            end
            check_outputs("down", exp_en, c < t_idle, 1'b0, 1'b0);
            seq_start_i = (c < t_idle) ? 1'($urandom_range(0, 1)) : 1'b0;
            ch_mask_i   = N'($urandom);
            if (c < t_idle) tick();
        end
        seq_start_i = 1'b0;
    endtask

    // stop_req < 0: none, 0: random point during ramp-up, > 0: stop sampled at that cycle.
    task automatic run_seq(input logic [N-1:0] m, input int dly, input int f, input int stop_req);
        int rise[N];
        int dd, cur, t_end, stop_at, w;
        bit flt, stopped;
        logic [N-1:0] exp_en, s_en;
        dd = (dly == 0) ? 1 : dly;
        cur = 0;
        t_end = -1;
        flt = 1'b0;
        for (int k = 0; k < N; k++) rise[k] = -1;
        for (int k = 0; k < N; k++) begin
            if (t_end < 0) begin
                if (m[k]) begin
                    rise[k] = cur + 1;
                    cur += 1 + dd;
                    if (k == f) begin
                        flt = 1'b1;
                        t_end = cur;
                    end
                end else begin
                    cur += 1;
                end
            end
        end
        if (t_end < 0) t_end = cur;
        stop_at = (stop_req == 0 && !flt) ? $urandom_range(1, t_end) : stop_req;

        seq_start_i = 1'b1;
        ch_mask_i   = m;
        dly_i       = CW'(dly);
        tick();
        seq_start_i = 1'b0;
        stopped = 1'b0;
        s_en = '0;
        for (int c = 0; c <= t_end; c++) begin
            exp_en = '0;
            for (int k = 0; k < N; k++) begin
                if (rise[k] >= 0 && rise[k] <= c && !(flt && c >= t_end)) exp_en[k] = 1'b1;
            end
            check_outputs("up", exp_en, c < t_end, !flt && c >= t_end, flt && c >= t_end);
            ch_mask_i   = N'($urandom);
            dly_i       = CW'($urandom);
            seq_start_i = (c < t_end) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stop_at > 0 && c == stop_at - 1) begin
                seq_stop_i = 1'b1;
                stopped = 1'b1;
                s_en = exp_en;
            end
            if (stopped || c < t_end) tick();
            if (stopped) break;
        end
        seq_start_i = 1'b0;
        seq_stop_i  = 1'b0;

        if (stopped) begin
            run_down(s_en, dd);
        end else if (flt) begin
            check_val("fault_ch", 32'(fault_ch_o), 32'(f));
            tick();
            check_outputs("fault_hold", '0, 1'b0, 1'b0, 1'b1);
            check_val("fault_ch_hold", 32'(fault_ch_o), 32'(f));
            seq_stop_i = 1'b1;
            tick();
            seq_stop_i = 1'b0;
            check_outputs("fault_clr", '0, 1'b0, 1'b0, 1'b0);
            check_val("fault_ch_clr", 32'(fault_ch_o), 32'd0);
        end else begin
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++) begin
                tick();
                check_outputs("on_hold", m, 1'b0, 1'b1, 1'b0);
            end
            seq_stop_i = 1'b1;
            tick();
            seq_stop_i = 1'b0;
            run_down(m, dd);
        end
    endtask

    initial begin
        logic [N-1:0] m;
        int f, j;
        bit seen;
        n_checks    = 0;
        n_fail      = 0;
        pg_follow   = 1'b0;
        en_prev     = '0;
        rst_n       = 1'b0;
        seq_start_i = 1'b0;
        seq_stop_i  = 1'b0;
        ch_mask_i   = '0;
        dly_i       = '0;
        pg_i        = '0;
        repeat (3) tick();
        check_outputs("reset", '0, 1'b0, 1'b0, 1'b0);
        check_val("reset.fault_ch", 32'(fault_ch_o), 32'd0);
        rst_n = 1'b1;

        // Power-good tracking the enables: rises land 5 cycles apart for a settle of 4.
        settle_pg('0);
        pg_follow = 1'b1;
        run_seq(3'b111, 4, -1, -1);
        pg_follow = 1'b0;

        settle_pg(3'b111);
        run_seq(3'b101, 0, -1, -1);

        settle_pg(3'b101);
        run_seq(3'b111, 8, 1, -1);

        settle_pg(3'b111);
        run_seq(3'b111, 4, -1, 8);

        // Power-good loss while ON.
        settle_pg(3'b111);
        seq_start_i = 1'b1;
        ch_mask_i   = 3'b111;
        dly_i       = CW'(2);
        tick();
        seq_start_i = 1'b0;
        for (int i = 0; i < 40 && !on_o; i++) tick();
        check_outputs("pgloss.pre", 3'b111, 1'b0, 1'b1, 1'b0);
        pg_i = 3'b011;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            tick();
            seen = fault_o;
        end
        check_val("pgloss.within3", 32'(seen), 32'd1);
        check_val("pgloss.fault_ch", 32'(fault_ch_o), 32'd2);
        check_val("pgloss.en", 32'(ldo_en_o), 32'd0);
        pg_i = 3'b111;
        tick();
        seq_stop_i = 1'b1;
        tick();
        seq_stop_i = 1'b0;
        check_outputs("pgloss.clr", '0, 1'b0, 1'b0, 1'b0);

        // Start and stop in the same cycle from IDLE.
        seq_start_i = 1'b1;
        seq_stop_i  = 1'b1;
        tick();
        seq_start_i = 1'b0;
        seq_stop_i  = 1'b0;
        check_outputs("startstop", '0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outputs("startstop2", '0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a ramp.
        seq_start_i = 1'b1;
        ch_mask_i   = 3'b111;
        dly_i       = CW'(5);
        tick();
        seq_start_i = 1'b0;
        repeat (3) tick();
        check_val("arst.pre_en", 32'(ldo_en_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("arst", '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        for (int it = 0; it < 40; it++) begin
            m = N'($urandom);
            f = -1;
            if (m != '0 && $urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, N - 1);
                for (int t = 0; t < N; t++) begin
                    if (f < 0 && m[(j + t) % N]) f = (j + t) % N;
                end
            end
            settle_pg((f >= 0) ? ~(N'(1) << f) : '1);
            run_seq(m, $urandom_range(0, 6), f, $urandom_range(0, 1) ? 0 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
